pad_cmd_responder: RTL and testbench

PAD_CMD_RESPONDER -- requirements
Module: pad_cmd_responder

---
 rtl/pad_cmd_responder.sv | 170 +++++++++++++++++
 tb/tb_pad_cmd_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pad_cmd_responder.sv
// rtl/pad_cmd_responder.sv - pad command responder: host read/write to internal memory bus and array execution handshake
module pad_cmd_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_en,
  input  logic              data_addr_valid,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              scan_start_exec,
  input  logic              trigger,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              exec_end,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              rd_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4,
    EXEC    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              dav_q, dav_d;
  logic              trig_q, trig_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rd_err_q, rd_err_d;
  logic              exec_end_q, exec_end_d;
  logic              exec_start_q, exec_start_d;
  logic              early_q, early_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic dav_edge, trig_edge;

  // armed_q stays low for the first cycle after reset so that an input
  // already high at release loads the history register instead of firing.
  assign dav_edge  = armed_q && data_addr_valid && !dav_q;
  assign trig_edge = armed_q && trigger && !trig_q;

  always_comb begin
    state_d      = state_q;
    dav_d        = data_addr_valid;
    trig_d       = trigger;
    armed_d      = 1'b1;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dout_d       = dout_q;
    rd_err_d     = rd_err_q;
    exec_end_d   = exec_end_q;
    exec_start_d = 1'b0;
    early_d      = early_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        if (chip_en) begin
          if (scan_start_exec && trig_edge) begin
            state_d      = EXEC;
            exec_start_d = 1'b1;
            exec_end_d   = 1'b0;
          end else if (!scan_start_exec && dav_edge) begin
            addr_d  = address_in;
            wdata_d = data_in;
            state_d = read_write ? RD_REQ : WR;
          end
        end
      end
      WR: begin
        if (mem_gnt) state_d = IDLE;
      end
      RD_REQ: begin
        if (mem_gnt) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
          early_d = mem_rvalid;
          if (mem_rvalid) dout_d = mem_rdata;
        end
      end
      RD_WAIT: begin
        // early_q: read data already arrived together with the grant
        if (early_q) begin
          state_d = RESP;
        end else if (mem_rvalid) begin
          dout_d  = mem_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          dout_d   = '1;
          rd_err_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      EXEC: begin
        if (exec_done) begin
          exec_end_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dav_q        <= 1'b0;
      trig_q       <= 1'b0;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dout_q       <= '0;
      rd_err_q     <= 1'b0;
      exec_end_q   <= 1'b0;
      exec_start_q <= 1'b0;
      early_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      dav_q        <= dav_d;
      trig_q       <= trig_d;
      armed_q      <= armed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dout_q       <= dout_d;
      rd_err_q     <= rd_err_d;
      exec_end_q   <= exec_end_d;
      exec_start_q <= exec_start_d;
      early_q      <= early_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req        = (state_q == WR) || (state_q == RD_REQ);
  assign mem_we         = (state_q == WR);
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign data_out       = dout_q;
  assign data_out_valid = (state_q == RESP);
  assign exec_end       = exec_end_q;
  assign exec_start     = exec_start_q;
  assign rd_err         = rd_err_q;

endmodule

// File: tb/tb_pad_cmd_responder.sv
// tb/tb_pad_cmd_responder.sv - directed vector bench for pad_cmd_responder
module tb_pad_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        chip_en, data_addr_valid, read_write, scan_start_exec, trigger;
  logic [15:0] address_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_valid, exec_end;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        exec_start, exec_done, rd_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pad_cmd_responder dut (
    .clk(clk), .rst(rst), .chip_en(chip_en), .data_addr_valid(data_addr_valid),
    .read_write(read_write), .address_in(address_in), .data_in(data_in),
    .scan_start_exec(scan_start_exec), .trigger(trigger),
    .data_out(data_out), .data_out_valid(data_out_valid), .exec_end(exec_end),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .exec_start(exec_start), .exec_done(exec_done), .rd_err(rd_err)
  );

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [31:0] data;
    int          gnt_dly;   // mem_req cycles before grant
    int          rv_dly;    // wait cycles after grant before rvalid (0 = with grant)
    logic [31:0] rdata;
    bit          drop_ce;
    int          ncyc;
    int          exp_lat;   // 0 = no response expected
    int          exp_req;
    logic [31:0] exp_dout;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input int idx, input vec_t v);
    int req_cnt, wait_cnt, valid_cnt, lat, bus_bad;
    bit granted;
    req_cnt = 0; wait_cnt = 0; valid_cnt = 0; lat = 0; bus_bad = 0; granted = 0;
    @(negedge clk);
    read_write = v.rd; address_in = v.addr; data_in = v.data; data_addr_valid = 1'b1;
    for (int cyc = 1; cyc <= v.ncyc; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        read_write = ~v.rd; address_in = ~v.addr; data_in = ~v.data;
        if (v.drop_ce) chip_en = 1'b0;
      end
      if (cyc == 3) data_addr_valid = 1'b0;
      if (data_out_valid) begin
        valid_cnt++;
        if (lat == 0) lat = cyc;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~v.rdata;
      if (mem_req) begin
        req_cnt++;
        if (mem_we !== ~v.rd || mem_addr !== v.addr || (!v.rd && mem_wdata !== v.data))
          bus_bad++;
        if (req_cnt > v.gnt_dly) begin
          mem_gnt = 1'b1; granted = 1'b1;
          if (v.rd && v.rv_dly == 0) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
        end
      end else if (granted && v.rd) begin
        wait_cnt++;
        if (wait_cnt == v.rv_dly) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; chip_en = 1'b1;
    chk($sformatf("v%0d_valid_pulses", idx), valid_cnt, (v.exp_lat != 0) ? 1 : 0);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_req_cycles", idx), req_cnt, v.exp_req);
    chk($sformatf("v%0d_bus_fields_bad", idx), bus_bad, 0);
    chk($sformatf("v%0d_data_out", idx), data_out, v.exp_dout);
    chk($sformatf("v%0d_rd_err", idx), rd_err, v.exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_start, n_req, n_end, n_valid;
    //        rd addr     data          gnt rv   rdata         ce ncyc lat req dout          err
    vecs[0] = '{0, 16'h0010, 32'hA5A5_0001, 2, 0,   32'h0,         0, 10, 0,  3, 32'h0,         0};
    vecs[1] = '{1, 16'h0020, 32'h0,         0, 0,   32'h1234_5678, 0, 10, 3,  1, 32'h1234_5678, 0};
    vecs[2] = '{1, 16'h0030, 32'h0,         0, 1,   32'hCAFE_BABE, 0, 10, 3,  1, 32'hCAFE_BABE, 0};
    vecs[3] = '{1, 16'h0040, 32'h0,         3, 4,   32'h0BAD_F00D, 1, 14, 9,  4, 32'h0BAD_F00D, 0};
    vecs[4] = '{0, 16'h0050, 32'h55AA_33CC, 0, 0,   32'h0,         0, 8,  0,  1, 32'h0BAD_F00D, 0};
    vecs[5] = '{1, 16'hFFFF, 32'h0,         1, 255, 32'h1111_2222, 0, 80, 67, 2, 32'hFFFF_FFFF, 1};
    vecs[6] = '{1, 16'h0001, 32'h0,         0, 2,   32'h8000_0001, 0, 10, 4,  1, 32'h8000_0001, 1};

    rst = 1'b1; chip_en = 1'b1; data_addr_valid = 1'b0; read_write = 1'b0;
    address_in = '0; data_in = '0; scan_start_exec = 1'b0; trigger = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; exec_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_ctrl", {data_out_valid, exec_end, exec_start, mem_req, mem_we, rd_err}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_cmd(i, vecs[i]);

    // execution handshake, with a strobe edge arriving while in EXEC
    @(negedge clk);
    scan_start_exec = 1'b1; trigger = 1'b1;
    @(negedge clk);
    chk("exec_start_pulse", exec_start, 1);
    chk("exec_end_low_at_start", exec_end, 0);
    scan_start_exec = 1'b0; data_addr_valid = 1'b1; trigger = 1'b0;
    n_start = 0; n_req = 0; n_end = 0;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk);
      n_start += int'(exec_start); n_req += int'(mem_req); n_end += int'(exec_end);
    end
    chk("exec_start_extra", n_start, 0);
    chk("exec_strobe_ignored", n_req, 0);
    chk("exec_end_early", n_end, 0);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    chk("exec_end_set", exec_end, 1);
    n_req = 0; n_end = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_req += int'(mem_req); n_end += int'(!exec_end);
    end
    chk("exec_dropped_edge_no_cmd", n_req, 0);
    chk("exec_end_held", n_end, 0);
    data_addr_valid = 1'b0; scan_start_exec = 1'b1; trigger = 1'b1;
    @(negedge clk);
    chk("exec2_clears_end", exec_end, 0);
    chk("exec2_start_pulse", exec_start, 1);
    exec_done = 1'b1; trigger = 1'b0;
    @(negedge clk);
    exec_done = 1'b0; scan_start_exec = 1'b0;
    @(negedge clk);

    // strobe held high for 10 cycles gives exactly one command
    read_write = 1'b0; address_in = 16'h0100; data_in = 32'h0000_0011;
    data_addr_valid = 1'b1; mem_gnt = 1'b1; n_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_req += int'(mem_req);
    end
    chk("held_strobe_one_cmd", n_req, 1);
    mem_gnt = 1'b0; data_addr_valid = 1'b0;
    @(negedge clk);

    // chip_en low blocks acceptance; raising it under a held strobe is no edge
    chip_en = 1'b0; read_write = 1'b1; data_addr_valid = 1'b1; n_req = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_req += int'(mem_req);
      if (c == 3) chip_en = 1'b1;
    end
    chk("chip_en_blocks", n_req, 0);
    data_addr_valid = 1'b0;
    @(negedge clk);

    // reset while in RD_WAIT, strobe held across release
    read_write = 1'b1; address_in = 16'h0077; data_addr_valid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rdwait_pre_rst_err", rd_err, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_data_out", data_out, 32'h0);
    chk("rst_mid_ctrl", {data_out_valid, exec_end, exec_start, mem_req, mem_we, rd_err}, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    rst = 1'b0;
    n_req = 0; n_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_req += int'(mem_req); n_valid += int'(data_out_valid);
    end
    chk("rst_release_no_cmd", n_req, 0);
    chk("rst_release_no_valid", n_valid, 0);
    data_addr_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
